// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu - multi-cycle multiply/divide unit for the EX stage
//
// Sits beside the ALU and receives the same two operands from ID/EX. Holds
// the architectural HI/LO registers that feed the EX result mux for
// mfhi/mflo. A mult/div computes its result at issue, parks it in pending
// registers, and only commits it to HI/LO after a fixed latency, during which
// busy is raised so hazard logic can stall dependent instructions in ID.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous, active-low; clears all state
//   A      in  32   operand 1 (rs value)
//   B      in  32   operand 2 (rt value)
//   MDUOp  in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                   101 mthi, 110 mtlo, 111 none
//   start  in   1   qualifies MDUOp for one cycle
//   busy   out  1   high while a mult/div is in flight
//   done   out  1   one-cycle pulse when HI/LO take a mult/div result
//   HI     out 32   HI register
//   LO     out 32   LO register
// ---------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_NOP   = 3'b111
  } mdu_op_t;

  state_t        state;
  state_t        next_state;
  mdu_op_t       op;
  logic [CW-1:0] cnt;

  logic          launch;
  logic          launch_mul;
  logic          complete;
  logic          write_hi;
  logic          write_lo;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic          signed_div;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   div_n;
  logic [31:0]   div_d;
  logic [31:0]   div_d_safe;
  logic [31:0]   uquot;
  logic [31:0]   urem;
  logic [31:0]   quot;
  logic [31:0]   rem;

  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_wr;

  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;
  logic          done_q;

  // Decode the request. Anything arriving while RUN is dropped on the floor,
  // including mthi/mtlo, because the pending result still owns HI/LO.
  // Completion is keyed off the counter value seen at the edge, so the edge
  // that retires an op still sees RUN and a start on that edge is ignored.
  always_comb begin
    op         = mdu_op_t'(MDUOp);
    launch     = 1'b0;
    launch_mul = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    if (start && (state == IDLE)) begin
      unique case (op)
        OP_MULT, OP_MULTU: begin
          launch     = 1'b1;
          launch_mul = 1'b1;
        end
        OP_DIV, OP_DIVU:   launch   = 1'b1;
        OP_MTHI:           write_hi = 1'b1;
        OP_MTLO:           write_lo = 1'b1;
        default:           ;
      endcase
    end
    complete = (state == RUN) && (cnt == CW'(1));
  end

  // Multiplier: both products are the low 64 bits of a 64x64 multiply, so the
  // signed case just needs the operands sign-extended first.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'b0, A} * {32'b0, B};
  end

  // Divider: one unsigned divider handles both flavours by dividing
  // magnitudes and fixing signs afterwards. This keeps the 0x80000000 / -1
  // case well-defined: the magnitude of 0x80000000 is itself as an unsigned
  // number, and the quotient sign is positive, giving LO=0x80000000, HI=0.
  // A zero divisor is swapped for 1 so the divider never sees 0; the result
  // is discarded in that case anyway.
  always_comb begin
    signed_div = (op == OP_DIV);
    a_neg      = signed_div && A[31];
    b_neg      = signed_div && B[31];
    div_n      = a_neg ? -A : A;
    div_d      = b_neg ? -B : B;
    div_d_safe = (div_d == 32'd0) ? 32'd1 : div_d;
    uquot      = div_n / div_d_safe;
    urem       = div_n % div_d_safe;
    quot       = (a_neg ^ b_neg) ? -uquot : uquot;
    rem        = a_neg ? -urem : urem;
  end

  // Select the result that will be parked for the op being launched.
  // A divide by zero still runs the full latency but never writes HI/LO.
  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    res_wr = 1'b1;
    unique case (op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        res_hi = rem;
        res_lo = quot;
        res_wr = (B != 32'd0);
      end
      default: res_wr = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (launch)   next_state = RUN;
      RUN:  if (complete) next_state = IDLE;
      default:            next_state = IDLE;
    endcase
  end

  // FSM outputs. busy comes straight from the state flop and done from its
  // own flop, so both are glitch-free registered signals.
  always_comb begin
    busy = (state == RUN);
    done = done_q;
  end

  // Latency counter: loaded with the op's cycle count at issue and counted
  // down on every RUN edge; the edge that sees 1 is the completion edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (launch) begin
      cnt <= launch_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Pending result registers. Operands are captured only here, so operand
  // changes after issue cannot affect the outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (launch) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= res_wr;
    end
  end

  // Architectural HI/LO. Written only at a completion edge or by mthi/mtlo,
  // which are mutually exclusive because mthi/mtlo require IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      HI <= '0;
      LO <= '0;
    end else if (complete) begin
      if (pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else begin
      if (write_hi) HI <= A;
      if (write_lo) LO <= A;
    end
  end

  // Completion pulse, visible for exactly the cycle after the retiring edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= complete;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu - self-checking bench for mdu
//
// A reference model tracks HI/LO/busy/done at the level of "an op issued at
// edge k retires at edge k+N", computing results with 64-bit integer
// arithmetic. Directed sequences exercise the documented scenarios, then a
// randomized phase mixes all opcodes, special operands and async resets.
// ---------------------------------------------------------------------------
module tb_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  mdu_op;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  bit          pend_wr;
  bit          exp_busy;
  bit          exp_done;
  bit          in_flight;
  int          edge_cnt;
  int          finish_edge;

  always #5 clk = ~clk;

  mdu #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .A    (a),
    .B    (b),
    .MDUOp(mdu_op),
    .start(start),
    .busy (busy),
    .done (done),
    .HI   (hi),
    .LO   (lo)
  );

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Architectural result of a mult/div from plain integer arithmetic.
  function automatic void computeResult(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y, output logic [31:0] rh,
                                        output logic [31:0] rl, output bit wr);
    longint sx, sy, ux, uy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    rh = '0;
    rl = '0;
    wr = 1'b1;
    p  = 0;
    q  = 0;
    r  = 0;
    case (op)
      3'd1: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin p = ux * uy; rh = p[63:32]; rl = p[31:0]; end
      3'd3: begin
        if (y == 32'd0) wr = 1'b0;
        else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
      end
      3'd4: begin
        if (y == 32'd0) wr = 1'b0;
        else begin q = ux / uy; r = ux % uy; rl = q[31:0]; rh = r[31:0]; end
      end
      default: wr = 1'b0;
    endcase
  endfunction

  function automatic void modelReset();
    exp_hi    = '0;
    exp_lo    = '0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    in_flight = 1'b0;
  endfunction

  // Advance the model by one clock edge given the inputs sampled there.
  function automatic void modelEdge(input bit st, input logic [2:0] op,
                                    input logic [31:0] x, input logic [31:0] y);
    bit was_busy;
    edge_cnt++;
    was_busy = in_flight;
    exp_done = 1'b0;
    if (was_busy) begin
      if (edge_cnt == finish_edge) begin
        if (pend_wr) begin
          exp_hi = pend_hi;
          exp_lo = pend_lo;
        end
        exp_done  = 1'b1;
        in_flight = 1'b0;
      end
    end else if (st) begin
      case (op)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          computeResult(op, x, y, pend_hi, pend_lo, pend_wr);
          in_flight   = 1'b1;
          finish_edge = edge_cnt + ((op <= 3'd2) ? MULT_N : DIV_N);
        end
        3'd5: exp_hi = x;
        3'd6: exp_lo = x;
        default: ;
      endcase
    end
    exp_busy = in_flight;
  endfunction

  // Drive one cycle of inputs (called at a negedge), step the model at the
  // following posedge and compare every output at the next negedge.
  task automatic applyStimulus(input bit st, input logic [2:0] op,
                               input logic [31:0] x, input logic [31:0] y);
    start  = st;
    mdu_op = op;
    a      = x;
    b      = y;
    @(posedge clk);
    modelEdge(st, op, x, y);
    @(negedge clk);
    checkOutput("busy", 32'(busy), 32'(exp_busy));
    checkOutput("done", 32'(done), 32'(exp_done));
    checkOutput("HI", hi, exp_hi);
    checkOutput("LO", lo, exp_lo);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, $urandom, $urandom);
  endtask

  // Async reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic asyncReset();
    start = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_HI", hi, 32'd0);
    checkOutput("rst_LO", lo, 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    reset    = 1'b0;
    start    = 1'b0;
    mdu_op   = 3'd0;
    a        = '0;
    b        = '0;
    edge_cnt = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("init_busy", 32'(busy), 32'd0);
    checkOutput("init_HI", hi, 32'd0);
    reset = 1'b1;
    $display("[TB] reset released");

    applyStimulus(1'b1, 3'd5, 32'h1234_5678, 32'd0);
    applyStimulus(1'b1, 3'd6, 32'h9ABC_DEF0, 32'd0);
    asyncReset();
    idleCycles(10);

    applyStimulus(1'b1, 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    idleCycles(MULT_N);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
    checkOutput("mult_done", 32'(done), 32'd1);
    idleCycles(1);
    applyStimulus(1'b1, 3'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    idleCycles(MULT_N);
    checkOutput("multu_hi", hi, 32'h0000_0002);
    checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

    applyStimulus(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2);
    idleCycles(DIV_N);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idleCycles(DIV_N);
    checkOutput("divovf_lo", lo, 32'h8000_0000);
    checkOutput("divovf_hi", hi, 32'h0000_0000);

    applyStimulus(1'b1, 3'd5, 32'h11, 32'd0);
    applyStimulus(1'b1, 3'd6, 32'h22, 32'd0);
    applyStimulus(1'b1, 3'd4, 32'd7, 32'd0);
    idleCycles(DIV_N);
    checkOutput("div0_hi", hi, 32'h11);
    checkOutput("div0_lo", lo, 32'h22);
    checkOutput("div0_done", 32'(done), 32'd1);

    applyStimulus(1'b1, 3'd4, 32'd100, 32'd7);
    idleCycles(2);
    applyStimulus(1'b1, 3'd1, 32'd5, 32'd6);
    idleCycles(6);
    applyStimulus(1'b1, 3'd1, 32'd9, 32'd9);
    checkOutput("rej_lo", lo, 32'd14);
    checkOutput("rej_hi", hi, 32'd2);
    checkOutput("rej_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 3'd2, 32'd3, 32'd5);
    checkOutput("accept_busy", 32'(busy), 32'd1);
    idleCycles(MULT_N);
    checkOutput("accept_lo", lo, 32'd15);

    applyStimulus(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
    checkOutput("mthi_hi", hi, 32'hDEAD_BEEF);
    checkOutput("mthi_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 3'd1, 32'd2, 32'd2);
    applyStimulus(1'b1, 3'd6, 32'hCAFE_F00D, 32'd0);
    checkOutput("mtlo_busy_lo", lo, 32'd15);
    idleCycles(MULT_N);
    checkOutput("mtlo_after_lo", lo, 32'd4);

    applyStimulus(1'b1, 3'd1, 32'd3, 32'd4);
    idleCycles(1);
    asyncReset();
    idleCycles(12);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);

    $display("[TB] random phase");
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        asyncReset();
      end else begin
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 9))
          0: y = 32'd0;
          1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
          2: begin x = 32'($urandom_range(0, 20)) - 32'd10; y = 32'($urandom_range(0, 6)) - 32'd3; end
          default: ;
        endcase
        applyStimulus($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), x, y);
      end
    end
    idleCycles(DIV_N + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit in the EX stage, beside the ALU. It consumes the same two 32-bit operands the ALU receives from the ID/EX register. It holds the HI/LO result registers, which feed the EX result mux for mfhi/mflo. While an operation is in flight it raises `busy` so hazard logic stalls any dependent mult/div/mfhi/mflo/mthi/mtlo in ID.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- A  input  32  operand 1 (rs value)
- B  input  32  operand 2 (rt value)
- MDUOp  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- start  input  1  qualifies MDUOp for one cycle
- busy  output  1  high while a mult/div is in flight
- done  output  1  one-cycle pulse when HI/LO take a mult/div result
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- FSM states: IDLE, RUN.
- IDLE with start=1 and MDUOp mult/multu/div/divu:
  - Latch the result computed from A, B into pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE with start=1 and MDUOp mthi/mtlo: write A into HI or LO at that edge; stay IDLE; no busy, no done.
- IDLE with start=0, or MDUOp none: hold.
- RUN: the counter decrements each edge. At the edge where the counter reaches 1: HI/LO take the pending values, done=1 for the following cycle, return to IDLE.
- RUN with start=1 (any op): ignored. Operands are already latched, so later changes to A/B have no effect.
- mult: signed 32×32 → 64; HI=product[63:32], LO=product[31:0]. multu: same, unsigned.
- div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B=0): the unit runs the full DIV_CYCLES with busy and done as normal. HI and LO keep their prior values.
- Reset (async low): HI=0, LO=0, busy=0, done=0, state IDLE, counter 0. Mid-operation reset aborts; no result is written after release.

## Timing
- Edge E0 samples start. busy=1 from after E0 through the edge E_N, N = MULT_CYCLES or DIV_CYCLES.
- At E_N: busy→0, HI/LO updated, done→1. At E_N+1: done→0.
- New start accepted at E_N+1 or later. A start sampled at E_N itself is ignored, because the state is still RUN.
- mthi/mtlo: HI/LO are visible the cycle after E0, with zero stall.
- busy is a registered output, high exactly N cycles per mult/div. done is registered, high exactly 1 cycle.
- HI/LO are stable at all times except at the completion edge and the mthi/mtlo edge.

## Test plan
- Reset then idle: reset=0 async mid-cycle → HI=LO=0, busy=done=0 immediately; stays so for 10 cycles after release with start=0.
- mult signed: A=0xFFFFFFFE (−2), B=0x00000003, start at E0 → busy high 5 cycles; at E5 HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulse 1 cycle. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- div signed: A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Then divu 7/0 with HI=0x11, LO=0x22 preloaded → busy 10 cycles, HI/LO unchanged, done pulses.
- Busy rejection: start divu 100/7, change A/B and pulse start mult at cycles 3 and at E10 → result is LO=14, HI=2 at E10; no second busy period; the mult issued at E11 is accepted.
- mthi/mtlo: start mthi A=0xDEADBEEF → HI=0xDEADBEEF next cycle, busy stays 0. mtlo while busy → ignored, LO unchanged.
- Reset mid-op: start mult 3×4, assert reset at cycle 2 → HI=LO=0, busy=0 at once. After release no done pulse, and HI/LO remain 0.
